// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave
//  Purpose  : Single-address I2C target. Oversamples SCL/SDA on clk, detects
//             START/STOP, matches a 7-bit address, then receives write bytes
//             (each ACKed) or transmits read bytes until the master NACKs.
//  Ports    : clk      - system clock
//             rst_n    - asynchronous active-low reset
//             scl      - bus clock from the master (input only)
//             sda      - open-drain data line (driven 0 or released)
//             tx_byte  - byte to transmit, captured when tx_load pulses
//             tx_load  - 1-clk pulse, tx_byte captured into the shifter
//             rx_byte  - last byte received on a write
//             rx_valid - 1-clk pulse when rx_byte updates
//             busy     - own address ACKed, transfer in progress
//             rw       - R/W bit of the current transfer (1 = read)
//  Revision : 1.0  initial release
// ============================================================================
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_byte,
  output logic       tx_load,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       rw
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WRITE     = 3'd3,
    S_WRITE_ACK = 3'd4,
    S_READ      = 3'd5,
    S_READ_ACK  = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  // Synchronizers plus one extra stage of history for edge detection
  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;

  state_t     r_state, w_state;
  logic [2:0] r_bit_cnt, w_bit_cnt;
  logic [7:0] r_shift, w_shift;
  // r_full: a rise has been seen that completes the current bit slot (8th
  // data bit or ACK bit), so the following fall ends the slot. This keeps the
  // SCL fall that follows a START from being mistaken for a bit boundary.
  logic       r_full, w_full;
  logic       r_sda_oe, w_sda_oe;
  logic       r_rw, w_rw;
  logic       r_busy, w_busy;
  logic [7:0] r_rx_byte, w_rx_byte;
  logic       r_rx_valid, w_rx_valid;
  logic       r_tx_load, w_tx_load;

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  assign w_scl_rise = r_scl_sync & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_sync & r_scl_prev;
  assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
  assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

  // Output enable is a flop with async reset, so reset releases SDA at once
  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign tx_load  = r_tx_load;
  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign rw       = r_rw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Idle bus level, so leaving reset creates no false edges
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd7;
      r_shift    <= 8'h00;
      r_full     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
    end else begin
      r_scl_meta <= scl;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= sda;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
      r_state    <= w_state;
      r_bit_cnt  <= w_bit_cnt;
      r_shift    <= w_shift;
      r_full     <= w_full;
      r_sda_oe   <= w_sda_oe;
      r_rw       <= w_rw;
      r_busy     <= w_busy;
      r_rx_byte  <= w_rx_byte;
      r_rx_valid <= w_rx_valid;
      r_tx_load  <= w_tx_load;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_bit_cnt  = r_bit_cnt;
    w_shift    = r_shift;
    w_full     = r_full;
    w_sda_oe   = r_sda_oe;
    w_rw       = r_rw;
    w_busy     = r_busy;
    w_rx_byte  = r_rx_byte;
    w_rx_valid = 1'b0;
    w_tx_load  = 1'b0;

    // START/STOP override everything; a simultaneous SCL edge is dropped
    if (w_start) begin
      w_state   = S_ADDR;
      w_bit_cnt = 3'd7;
      w_full    = 1'b0;
      w_sda_oe  = 1'b0;
      w_busy    = 1'b0;
    end else if (w_stop) begin
      w_state  = S_IDLE;
      w_full   = 1'b0;
      w_sda_oe = 1'b0;
      w_busy   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_sda_oe = 1'b0;

        S_ADDR, S_WRITE: begin
          if (w_scl_rise) begin
            w_shift = {r_shift[6:0], r_sda_sync};
            if (r_bit_cnt == 3'd0) w_full = 1'b1;
            else                   w_bit_cnt = r_bit_cnt - 3'd1;
          end else if (w_scl_fall && r_full) begin
            w_full    = 1'b0;
            w_bit_cnt = 3'd7;
            if (r_state == S_WRITE) begin
              w_rx_byte  = r_shift;
              w_rx_valid = 1'b1;
              w_sda_oe   = 1'b1;
              w_state    = S_WRITE_ACK;
            end else if (r_shift[7:1] == ADDR) begin
              w_rw     = r_shift[0];
              w_busy   = 1'b1;
              w_sda_oe = 1'b1;
              w_state  = S_ADDR_ACK;
            end else begin
              w_sda_oe = 1'b0;
              w_state  = S_WAIT_STOP;
            end
          end
        end

        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_bit_cnt = 3'd7;
            if (r_rw) begin
              w_tx_load = 1'b1;
              w_shift   = tx_byte;
              w_sda_oe  = ~tx_byte[7];
              w_state   = S_READ;
            end else begin
              w_sda_oe = 1'b0;
              w_state  = S_WRITE;
            end
          end
        end

        S_WRITE_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe = 1'b0;
            w_state  = S_WRITE;
          end
        end

        // r_shift[7] is always the bit currently on the bus
        S_READ: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd0) begin
              w_sda_oe = 1'b0;
              w_full   = 1'b0;
              w_state  = S_READ_ACK;
            end else begin
              w_shift   = {r_shift[6:0], 1'b0};
              w_sda_oe  = ~r_shift[6];
              w_bit_cnt = r_bit_cnt - 3'd1;
            end
          end
        end

        S_READ_ACK: begin
          if (w_scl_rise) begin
            if (r_sda_sync) w_state = S_WAIT_STOP;
            else            w_full  = 1'b1;
          end else if (w_scl_fall && r_full) begin
            w_full    = 1'b0;
            w_tx_load = 1'b1;
            w_shift   = tx_byte;
            w_sda_oe  = ~tx_byte[7];
            w_bit_cnt = 3'd7;
            w_state   = S_READ;
          end
        end

        S_WAIT_STOP: w_sda_oe = 1'b0;

        default: begin
          w_state  = S_IDLE;
          w_sda_oe = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave
//  Purpose  : Directed bench for i2c_slave. The bench plays the bus master
//             with bit-level tasks on an open-drain SDA with pull-up.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_slave;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_oe = 1'b0;
  logic [7:0] tx_byte = 8'h3C;
  logic       tx_load, rx_valid, busy, rw;
  logic [7:0] rx_byte;
  wire        sda;

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rx_cnt  = 0;
  int         tx_cnt  = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] rx_log[$];

  always #10 clk = ~clk;

  i2c_slave #(.ADDR(7'h50)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .tx_byte  (tx_byte),
    .tx_load  (tx_load),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .busy     (busy),
    .rw       (rw)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_log.push_back(rx_byte);
    end
    if (tx_load) tx_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_start();
    m_sda_oe = 1'b0; tick(Q);
    scl = 1'b1;      tick(Q);
    m_sda_oe = 1'b1; tick(Q);
    scl = 1'b0;      tick(Q);
  endtask

  task automatic bus_stop();
    m_sda_oe = 1'b1; tick(Q);
    scl = 1'b1;      tick(Q);
    m_sda_oe = 1'b0; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    m_sda_oe = ~b; tick(Q);
    scl = 1'b1;    tick(2 * Q);
    scl = 1'b0;    tick(Q);
  endtask

  task automatic get_bit(output logic b);
    m_sda_oe = 1'b0; tick(Q);
    scl = 1'b1;      tick(Q);
    b = sda;         tick(Q);
    scl = 1'b0;      tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_err);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack_err);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  initial begin
    logic       ae;
    logic [7:0] d;
    logic [7:0] wr_data [3];
    int         base;
    wr_data[0] = 8'h11;
    wr_data[1] = 8'h22;
    wr_data[2] = 8'h33;

    // Reset state
    tick(3);
    check("rst_sda", sda, 1'b1);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_load", tx_load, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rw", rw, 1'b0);
    rst_n = 1'b1;
    tick(4);

    // Single-byte write of A5 to 0x50
    bus_start();
    write_byte(8'hA0, ae);
    check("w1_addr_ack", ae, 1'b0);
    check("w1_busy", busy, 1'b1);
    check("w1_rw", rw, 1'b0);
    write_byte(8'hA5, ae);
    check("w1_data_ack", ae, 1'b0);
    check("w1_rx_cnt", rx_cnt, 1);
    check("w1_rx_byte", rx_byte, 8'hA5);
    bus_stop();
    tick(2);
    check("w1_busy_stop", busy, 1'b0);

    // Single-byte read, master NACKs
    tx_byte = 8'h3C;
    bus_start();
    write_byte(8'hA1, ae);
    check("r1_addr_ack", ae, 1'b0);
    check("r1_tx_cnt_first", tx_cnt, 1);
    read_byte(1'b1, d);
    check("r1_data", d, 8'h3C);
    check("r1_rw", rw, 1'b1);
    check("r1_busy_wait_stop", busy, 1'b1);
    check("r1_tx_cnt", tx_cnt, 1);
    bus_stop();
    tick(2);
    check("r1_busy_stop", busy, 1'b0);
    check("r1_rx_cnt", rx_cnt, 1);

    // Write to a foreign address 0x51
    busy_seen = 1'b0;
    base = rx_cnt;
    bus_start();
    write_byte(8'hA2, ae);
    check("na_ack_error", ae, 1'b1);
    bus_stop();
    tick(2);
    check("na_rx_cnt", rx_cnt, base);
    check("na_busy_seen", busy_seen, 1'b0);

    // Multi-byte write
    base = rx_cnt;
    bus_start();
    write_byte(8'hA0, ae);
    check("mw_addr_ack", ae, 1'b0);
    for (int k = 0; k < 3; k++) begin
      write_byte(wr_data[k], ae);
      check("mw_data_ack", ae, 1'b0);
    end
    bus_stop();
    tick(2);
    check("mw_rx_cnt", rx_cnt, base + 3);
    for (int k = 0; k < 3; k++)
      check("mw_rx_order", rx_log[base + k], wr_data[k]);

    // Multi-byte read: master ACKs the first byte, NACKs the second
    base = tx_cnt;
    tx_byte = 8'h3C;
    bus_start();
    write_byte(8'hA1, ae);
    check("mr_addr_ack", ae, 1'b0);
    tx_byte = 8'hC3;  // first byte already captured at the address-ACK fall
    read_byte(1'b0, d);
    check("mr_byte0", d, 8'h3C);
    read_byte(1'b1, d);
    check("mr_byte1", d, 8'hC3);
    bus_stop();
    tick(2);
    check("mr_tx_cnt", tx_cnt, base + 2);

    // Repeated START in the middle of a write byte
    base = rx_cnt;
    bus_start();
    write_byte(8'hA0, ae);
    check("rs_addr_ack", ae, 1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    bus_start();
    check("rs_busy", busy, 1'b0);
    check("rs_rx_cnt", rx_cnt, base);
    check("rs_rx_byte", rx_byte, 8'h33);
    bus_stop();
    tick(2);

    // Reset during the 4th bit of a read byte (slave driving 0)
    tx_byte = 8'h00;
    bus_start();
    write_byte(8'hA1, ae);
    check("rr_addr_ack", ae, 1'b0);
    for (int k = 0; k < 3; k++) get_bit(ae);
    m_sda_oe = 1'b0; tick(Q);
    scl = 1'b1;      tick(Q / 2);
    check("rr_sda_driven", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rr_sda_released", sda, 1'b1);
    check("rr_busy", busy, 1'b0);
    check("rr_rw", rw, 1'b0);
    check("rr_rx_byte", rx_byte, 8'h00);
    check("rr_rx_valid", rx_valid, 1'b0);
    check("rr_tx_load", tx_load, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    scl = 1'b0;
    tick(Q);
    bus_start();
    write_byte(8'hA0, ae);
    check("rr_after_ack", ae, 1'b0);
    check("rr_after_busy", busy, 1'b1);
    bus_stop();
    tick(2);
    check("rr_after_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave.md
# i2c_slave

Single-address I2C target that answers the team's `i2c_master` on the same two-wire bus. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, then receives write bytes or transmits read bytes. Sits on the board/testbench bus beside the master, with `pullup(sda)` external and SDA open-drain.

## Interface

Parameters:
- `ADDR`, default 7'h50: own 7-bit address.

Ports:
- `clk`  in  1  system clock (50 MHz nominal).
- `rst_n`  in  1  reset; asynchronous, active-low.
- `scl`  in  1  bus clock from the master.
- `sda`  inout  1  open-drain; only ever driven 0 or released (Z).
- `tx_byte`  in  8  byte to send on a read; sampled when `tx_load` pulses.
- `tx_load`  out  1  one-clk pulse when `tx_byte` is captured into the shifter.
- `rx_byte`  out  8  last byte received on a write; held until the next one.
- `rx_valid`  out  1  one-clk pulse when `rx_byte` updates.
- `busy`  out  1  high from the own-address ACK until STOP or a repeated START.
- `rw`  out  1  R/W bit of the current addressed transfer (1 = read).

## Operation

- Sync: `scl` and `sda` each pass through a 2-FF synchronizer. Edges are detected on the synchronized values. All decisions use synchronized signals.
- START: sync SDA 1→0 while sync SCL = 1. STOP: sync SDA 0→1 while SCL = 1. Both are honoured in every state, including mid-byte.
  - START → ADDR, with bit counter = 7.
  - STOP → IDLE, SDA released.
- States and transitions:
  - IDLE: SDA released; waits for START.
  - ADDR: shift SDA in on each SCL rise, MSB first. On the SCL fall after the 8th bit:
    - If bits[7:1] == `ADDR`: latch `rw`, set `busy`, go to ADDR_ACK and drive SDA low.
    - Otherwise go to WAIT_STOP with SDA released.
  - ADDR_ACK: hold SDA low until the next SCL fall. Then:
    - If `rw` = 0: go to WRITE.
    - If `rw` = 1: pulse `tx_load`, load the shifter, drive bit 7 and go to READ.
  - WRITE: shift 8 bits on SCL rises. On the 8th-bit SCL fall: update `rx_byte`, pulse `rx_valid`, drive ACK and go to WRITE_ACK. Every data byte is ACKed.
  - WRITE_ACK: release SDA on the next SCL fall and go to WRITE for the next byte.
  - READ: on each SCL fall, drive the next bit (0 → drive low, 1 → release). On the fall after bit 0, release SDA and go to READ_ACK.
  - READ_ACK: sample SDA on the SCL rise.
    - Sampled 0 (ACK): on the next fall, pulse `tx_load`, reload and drive bit 7, go to READ.
    - Sampled 1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: SDA released and the bus is ignored until START or STOP.
- Widths: bit counter is 3 bits and wraps 0→7 only on a byte boundary. Shifters are 8 bits.
- General call (address 0) is not supported. No clock stretching: SCL is input only.

## Timing

- Reset values while `rst_n` = 0:
  - SDA released; state IDLE.
  - `rx_byte` = 8'h00; `rx_valid`, `tx_load`, `busy`, `rw` = 0.
- Reset asserted mid-transfer releases SDA immediately (asynchronously), before any clk edge.
- SCL high and low phases must each be ≥ 4 clk. SDA setup to the SCL rise must be ≥ 3 clk.
- SDA output changes 3 clk after the physical SCL fall: 2 sync stages plus 1 registered output. This is well inside the SCL low phase.
- `rx_valid` and `tx_load` are each exactly 1 clk wide.
- `tx_byte` must be stable on the clk where `tx_load` = 1. The first read byte is captured at the fall ending the address ACK.
- Simultaneous events:
  - START or STOP detected on the same clk as an SCL edge takes priority; the edge is discarded.
  - A repeated START inside a byte aborts it: no `rx_valid` pulse, and `busy` drops the following clk.
- `busy` falls 1 clk after STOP or START is detected.

## Test plan

- Write A5 to 0x50 → slave ACKs the address and data. `rx_byte` = 0xA5 with a single `rx_valid` pulse. Master reports `ack_error` = 0. `busy` 1 then 0 after STOP.
- Read from 0x50 with `tx_byte` = 0x3C → one `tx_load` pulse. Master `rx_byte` = 0x3C, `rx_valid` = 1, `rw` = 1. Master NACK → WAIT_STOP, then IDLE on STOP.
- Write to 0x51 → SDA never driven. Master `ack_error` = 1. No `rx_valid`, `busy` stays 0.
- Multi-byte write 0x11, 0x22, 0x33 → three `rx_valid` pulses in order, each byte ACKed.
- Multi-byte read with master ACK then NACK → two `tx_load` pulses; bytes 0x3C then 0xC3 received by the master.
- `rst_n` low during the 4th bit of a read byte → SDA released the same instant. All outputs at reset values. The next START to 0x50 is ACKed normally.
